// File: rtl/uart_register_responder_if.sv
// Byte-stream and register-bus signals of the UART register responder.
// master is the responder's view; slave is the UART controller / register file view.
interface uart_register_responder_if #(
    parameter int ADDRESS_BITS = 4
);
    logic [7:0]              receive_data;
    logic                    receive_valid;
    logic                    receive_ready;
    logic [7:0]              transmit_data;
    logic                    transmit_valid;
    logic                    transmit_ready;
    logic [ADDRESS_BITS-1:0] reg_address;
    logic [7:0]              reg_write_data;
    logic                    reg_write_enable;
    logic [7:0]              reg_read_data;

    modport master (
        input  receive_data, receive_valid, transmit_ready, reg_read_data,
        output receive_ready, transmit_data, transmit_valid,
               reg_address, reg_write_data, reg_write_enable
    );

    modport slave (
        output receive_data, receive_valid, transmit_ready, reg_read_data,
        input  receive_ready, transmit_data, transmit_valid,
               reg_address, reg_write_data, reg_write_enable
    );
endinterface

// File: rtl/uart_register_responder.sv
// Serial command responder: host read/write access to a small register bus, one reply byte per command.
// Optional write-data timeout enabled by defining UART_RESPONDER_TIMEOUT_EN.
module uart_register_responder #(
    parameter int         ADDRESS_BITS   = 4,
    parameter logic [7:0] ACK_BYTE       = 8'h06,
    parameter logic [7:0] NAK_BYTE       = 8'h15,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                     clock,
    input  logic                     reset,
    uart_register_responder_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, WAIT_DATA, RESPOND} state_t;

    // Command bits between the address field and the write flag must be zero.
    localparam logic [6:0] RESERVED_MASK = 7'(7'h7F << ADDRESS_BITS);

    if (ADDRESS_BITS < 1 || ADDRESS_BITS > 7 || TIMEOUT_CYCLES < 1) begin : gBadParams
        $error("uart_register_responder: parameter out of range");
    end

    state_t                  state_q;
    logic                    receiveReady_q;
    logic                    transmitValid_q;
    logic [7:0]              transmitData_q;
    logic [ADDRESS_BITS-1:0] address_q;
    logic [7:0]              writeData_q;
    logic                    writeEnable_q;

`ifdef UART_RESPONDER_TIMEOUT_EN
    localparam int COUNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
    logic [COUNT_BITS-1:0] waitCount_q;
`endif

    logic rxAccept;
    logic reservedSet;

    assign rxAccept    = bus.receive_valid && receiveReady_q;
    assign reservedSet = |(bus.receive_data[6:0] & RESERVED_MASK);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            receiveReady_q  <= 1'b0;
            transmitValid_q <= 1'b0;
            transmitData_q  <= 8'h00;
            address_q       <= '0;
            writeData_q     <= 8'h00;
            writeEnable_q   <= 1'b0;
`ifdef UART_RESPONDER_TIMEOUT_EN
            waitCount_q     <= '0;
`endif
        end else begin
            writeEnable_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    receiveReady_q <= 1'b1;
                    if (rxAccept) begin
                        if (reservedSet) begin
                            transmitData_q  <= NAK_BYTE;
                            transmitValid_q <= 1'b1;
                            receiveReady_q  <= 1'b0;
                            state_q         <= RESPOND;
                        end else begin
                            address_q <= bus.receive_data[ADDRESS_BITS-1:0];
                            if (bus.receive_data[7]) begin
                                state_q <= WAIT_DATA;
`ifdef UART_RESPONDER_TIMEOUT_EN
                                waitCount_q <= '0;
`endif
                            end else begin
                                receiveReady_q <= 1'b0;
                                state_q        <= READ;
                            end
                        end
                    end
                end
                READ: begin
                    transmitData_q  <= bus.reg_read_data;
                    transmitValid_q <= 1'b1;
                    state_q         <= RESPOND;
                end
                WAIT_DATA: begin
                    // A data byte arriving on the timeout cycle still wins.
                    if (rxAccept) begin
                        writeData_q     <= bus.receive_data;
                        writeEnable_q   <= 1'b1;
                        transmitData_q  <= ACK_BYTE;
                        transmitValid_q <= 1'b1;
                        receiveReady_q  <= 1'b0;
                        state_q         <= RESPOND;
                    end
`ifdef UART_RESPONDER_TIMEOUT_EN
                    else if (waitCount_q == COUNT_BITS'(TIMEOUT_CYCLES - 1)) begin
                        transmitData_q  <= NAK_BYTE;
                        transmitValid_q <= 1'b1;
                        receiveReady_q  <= 1'b0;
                        state_q         <= RESPOND;
                    end else begin
                        waitCount_q <= waitCount_q + 1'b1;
                    end
`endif
                end
                RESPOND: begin
                    if (bus.transmit_ready) begin
                        transmitValid_q <= 1'b0;
                        receiveReady_q  <= 1'b1;
                        state_q         <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.receive_ready    = receiveReady_q;
    assign bus.transmit_valid   = transmitValid_q;
    assign bus.transmit_data    = transmitData_q;
    assign bus.reg_address      = address_q;
    assign bus.reg_write_data   = writeData_q;
    assign bus.reg_write_enable = writeEnable_q;
endmodule

// File: tb/tb_uart_register_responder.sv
// Directed bench for uart_register_responder: scoreboard of expected reply bytes plus register-bus checks.
// The timeout scenario runs only when UART_RESPONDER_TIMEOUT_EN is defined.
module tb_uart_register_responder;
    localparam int ADDR_BITS = 4;
    localparam int TIMEOUT   = 20;
    localparam int LIMIT     = 200;

    logic clock;
    logic reset;

    uart_register_responder_if #(.ADDRESS_BITS(ADDR_BITS)) bus ();

    uart_register_responder #(
        .ADDRESS_BITS  (ADDR_BITS),
        .ACK_BYTE      (8'h06),
        .NAK_BYTE      (8'h15),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int checkCount  = 0;
    int errorCount  = 0;
    int respCount   = 0;
    int strobeCount = 0;
    int expResponses = 0;
    int expStrobes   = 0;
    logic [7:0] expQueue[$];
    logic [7:0] regs[2**ADDR_BITS];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] initValue(input int addr);
        return (addr == 3) ? 8'hA5 : 8'(8'h10 + addr);
    endfunction

    // Register file model: reset to known contents, written by the strobe.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 2**ADDR_BITS; i++) regs[i] <= initValue(i);
        end else if (bus.reg_write_enable) begin
            regs[bus.reg_address] <= bus.reg_write_data;
        end
    end

    assign bus.reg_read_data = regs[bus.reg_address];

    always @(posedge clock) begin
        if (bus.transmit_valid && bus.transmit_ready) respCount <= respCount + 1;
        if (bus.reg_write_enable) strobeCount <= strobeCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Offer one byte on the receive stream; returns at the negedge after its transfer edge.
    task automatic applyStimulus(input logic [7:0] b);
        int waited = 0;
        @(negedge clock);
        bus.receive_data  = b;
        bus.receive_valid = 1'b1;
        while (!bus.receive_ready && waited < LIMIT) begin
            @(negedge clock);
            waited++;
        end
        checkOutput("rx_accept", {31'd0, bus.receive_ready}, 32'd1);
        @(negedge clock);
        bus.receive_valid = 1'b0;
    endtask

    task automatic expectResponse(input logic [7:0] b);
        expQueue.push_back(b);
        expResponses++;
    endtask

    // Wait for a reply, compare it against the scoreboard head, then accept it.
    task automatic collectResponse(input string tag);
        int waited = 0;
        logic [7:0] expected;
        while (!bus.transmit_valid && waited < LIMIT) begin
            @(negedge clock);
            waited++;
        end
        checkOutput({tag, "_valid"}, {31'd0, bus.transmit_valid}, 32'd1);
        if (expQueue.size() == 0) begin
            checkOutput({tag, "_unexpected"}, 32'd1, 32'd0);
        end else begin
            expected = expQueue.pop_front();
            checkOutput({tag, "_data"}, {24'd0, bus.transmit_data}, {24'd0, expected});
        end
        bus.transmit_ready = 1'b1;
        @(negedge clock);
        bus.transmit_ready = 1'b0;
        checkOutput({tag, "_drop"}, {31'd0, bus.transmit_valid}, 32'd0);
        checkOutput({tag, "_rx_ready"}, {31'd0, bus.receive_ready}, 32'd1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rx_ready"}, {31'd0, bus.receive_ready}, 32'd0);
        checkOutput({tag, "_tx_valid"}, {31'd0, bus.transmit_valid}, 32'd0);
        checkOutput({tag, "_tx_data"}, {24'd0, bus.transmit_data}, 32'd0);
        checkOutput({tag, "_address"}, {28'd0, bus.reg_address}, 32'd0);
        checkOutput({tag, "_wdata"}, {24'd0, bus.reg_write_data}, 32'd0);
        checkOutput({tag, "_we"}, {31'd0, bus.reg_write_enable}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset              = 1'b1;
        bus.receive_data   = 8'h00;
        bus.receive_valid  = 1'b0;
        bus.transmit_ready = 1'b0;
        repeat (3) @(negedge clock);
        checkResetValues("reset");
        reset = 1'b0;
        @(negedge clock);
        checkOutput("release_rx_ready", {31'd0, bus.receive_ready}, 32'd1);

        $display("[TB] read of address 3");
        expectResponse(8'hA5);
        applyStimulus(8'h03);
        checkOutput("read_address", {28'd0, bus.reg_address}, 32'd3);
        checkOutput("read_early_valid", {31'd0, bus.transmit_valid}, 32'd0);
        @(negedge clock);
        checkOutput("read_latency", {31'd0, bus.transmit_valid}, 32'd1);
        collectResponse("read3");
        repeat (5) @(negedge clock);
        checkOutput("read_one_response", respCount, expResponses);

        $display("[TB] write 0x3C to address 5");
        applyStimulus(8'h85);
        expectResponse(8'h06);
        applyStimulus(8'h3C);
        expStrobes++;
        checkOutput("write_we", {31'd0, bus.reg_write_enable}, 32'd1);
        checkOutput("write_address", {28'd0, bus.reg_address}, 32'd5);
        checkOutput("write_wdata", {24'd0, bus.reg_write_data}, 32'h3C);
        checkOutput("write_ack_valid", {31'd0, bus.transmit_valid}, 32'd1);
        @(negedge clock);
        checkOutput("write_we_single", {31'd0, bus.reg_write_enable}, 32'd0);
        checkOutput("write_strobes", strobeCount, expStrobes);
        collectResponse("write5");

        $display("[TB] read back address 5");
        expectResponse(8'h3C);
        applyStimulus(8'h05);
        collectResponse("readback5");

        $display("[TB] malformed command then normal read");
        expectResponse(8'h15);
        applyStimulus(8'h40);
        collectResponse("malformed");
        checkOutput("malformed_no_write", strobeCount, expStrobes);
        expectResponse(initValue(1));
        applyStimulus(8'h01);
        collectResponse("after_malformed");

        $display("[TB] backpressure on read response");
        expectResponse(8'hA5);
        applyStimulus(8'h03);
        repeat (2) @(negedge clock);
        for (int i = 0; i < 50; i++) begin
            checkOutput("bp_valid", {31'd0, bus.transmit_valid}, 32'd1);
            checkOutput("bp_data", {24'd0, bus.transmit_data}, 32'hA5);
            checkOutput("bp_rx_ready", {31'd0, bus.receive_ready}, 32'd0);
            @(negedge clock);
        end
        collectResponse("backpressure");
        checkOutput("bp_responses", respCount, expResponses);

        $display("[TB] reset in the middle of a write");
        applyStimulus(8'h87);
        reset = 1'b1;
        #2;
        checkResetValues("midreset");
        repeat (2) @(negedge clock);
        checkOutput("midreset_held_we", {31'd0, bus.reg_write_enable}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("midreset_rx_ready", {31'd0, bus.receive_ready}, 32'd1);
        checkOutput("midreset_no_response", {31'd0, bus.transmit_valid}, 32'd0);
        expectResponse(initValue(2));
        applyStimulus(8'h02);
        collectResponse("after_reset");
        checkOutput("midreset_no_write", strobeCount, expStrobes);

`ifdef UART_RESPONDER_TIMEOUT_EN
        begin
            int waited = 0;
            $display("[TB] write timeout");
            expectResponse(8'h15);
            applyStimulus(8'h82);
            while (!bus.transmit_valid && waited < LIMIT) begin
                @(negedge clock);
                waited++;
            end
            checkOutput("timeout_cycles", waited, TIMEOUT);
            collectResponse("timeout");
            checkOutput("timeout_no_write", strobeCount, expStrobes);
            expectResponse(8'h06);
            applyStimulus(8'h82);
            applyStimulus(8'h11);
            expStrobes++;
            collectResponse("timeout_write");
            checkOutput("timeout_write_strobe", strobeCount, expStrobes);
            checkOutput("timeout_write_reg", {24'd0, regs[2]}, 32'h11);
        end
`endif

        repeat (3) @(negedge clock);
        checkOutput("scoreboard_empty", expQueue.size(), 0);
        checkOutput("total_responses", respCount, expResponses);
        checkOutput("total_strobes", strobeCount, expStrobes);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
